// File: rtl/mont_exp_seq_if.sv
// Host-side and multiplier-side bundles for the Montgomery exponentiation sequencer.
interface mont_exp_seq_if #(
    parameter int DATA_W = 512,
    parameter int EXP_W  = 512,
    parameter int CNT_W  = 11
);
    logic              start;
    logic [DATA_W-1:0] x_mont;
    logic [DATA_W-1:0] one_mont;
    logic [EXP_W-1:0]  exp;
    logic [DATA_W-1:0] mod;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              busy;
    logic [CNT_W-1:0]  mult_count;

    modport master (
        output start, x_mont, one_mont, exp, mod,
        input  result, done, busy, mult_count
    );
    modport slave (
        input  start, x_mont, one_mont, exp, mod,
        output result, done, busy, mult_count
    );
endinterface

interface mont_mm_if #(
    parameter int DATA_W = 512
);
    logic              mm_start;
    logic [DATA_W-1:0] mm_a;
    logic [DATA_W-1:0] mm_b;
    logic [DATA_W-1:0] mm_m;
    logic [DATA_W-1:0] mm_result;
    logic              mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );
    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_exp_seq.sv
// Left-to-right square-and-multiply in the Montgomery domain over one shared multiplier.
// Optional build macro MONT_EXP_SKIP_LZ_EN: skip squarings until the first set exponent bit.
module mont_exp_seq #(
    parameter int DATA_W = 512,
    parameter int EXP_W  = 512,
    parameter int CNT_W  = 11
) (
    input  logic          clk,
    input  logic          reset,
    mont_exp_seq_if.slave host,
    mont_mm_if.master     mm
);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SQ_ISS, S_SQ_WAIT, S_MU_ISS,
        S_MU_WAIT, S_PO_ISS, S_PO_WAIT, S_FIN
    } state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_x, r_m;
    logic [EXP_W-1:0]  r_e;
    logic [DATA_W-1:0] r_acc, w_acc_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DATA_W-1:0] r_result, w_result_next;
    logic [DATA_W-1:0] r_mm_a, r_mm_b, r_mm_m;
    logic [DATA_W-1:0] w_mm_a_next, w_mm_b_next, w_mm_m_next;
    logic              w_accept;
    logic              w_next_bit;

    assign w_accept = (r_state == S_IDLE) && host.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_mm_a   <= '0;
            r_mm_b   <= '0;
            r_mm_m   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_result <= w_result_next;
            r_mm_a   <= w_mm_a_next;
            r_mm_b   <= w_mm_b_next;
            r_mm_m   <= w_mm_m_next;
            if (w_accept) begin
                r_x <= host.x_mont;
                r_m <= host.mod;
                r_e <= host.exp;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_acc_next    = r_acc;
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;
        w_mm_a_next   = r_mm_a;
        w_mm_b_next   = r_mm_b;
        w_mm_m_next   = r_mm_m;
        w_next_bit    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (host.start) begin
                    w_acc_next   = host.one_mont;
                    w_idx_next   = IDX_W'(EXP_W - 1);
                    w_cnt_next   = '0;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef MONT_EXP_SKIP_LZ_EN
                // A is still one_mont here, so squaring it would be wasted work.
                if (r_e == '0)
                    w_state_next = S_PO_ISS;
                else if (r_e[r_idx])
                    w_state_next = S_MU_ISS;
                else
                    w_idx_next = r_idx - IDX_W'(1);
`else
                w_state_next = S_SQ_ISS;
`endif
            end
            S_SQ_ISS: begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_state_next = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm.mm_done) begin
                    w_acc_next = mm.mm_result;
                    if (r_e[r_idx])
                        w_state_next = S_MU_ISS;
                    else
                        w_next_bit = 1'b1;
                end
            end
            S_MU_ISS: begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_state_next = S_MU_WAIT;
            end
            S_MU_WAIT: begin
                if (mm.mm_done) begin
                    w_acc_next = mm.mm_result;
                    w_next_bit = 1'b1;
                end
            end
            S_PO_ISS: begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_state_next = S_PO_WAIT;
            end
            S_PO_WAIT: begin
                if (mm.mm_done) begin
                    w_result_next = mm.mm_result;
                    w_state_next  = S_FIN;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        if (w_next_bit) begin
            if (r_idx == '0) begin
                w_state_next = S_PO_ISS;
            end else begin
                w_idx_next   = r_idx - IDX_W'(1);
                w_state_next = S_SQ_ISS;
            end
        end

        // Operands are latched on entry to an issue state and held through the wait.
        case (w_state_next)
            S_SQ_ISS: begin
                w_mm_a_next = w_acc_next;
                w_mm_b_next = w_acc_next;
                w_mm_m_next = r_m;
            end
            S_MU_ISS: begin
                w_mm_a_next = w_acc_next;
                w_mm_b_next = r_x;
                w_mm_m_next = r_m;
            end
            S_PO_ISS: begin
                w_mm_a_next = w_acc_next;
                w_mm_b_next = {{(DATA_W-1){1'b0}}, 1'b1};
                w_mm_m_next = r_m;
            end
            default: ;
        endcase
    end

    assign host.result     = r_result;
    assign host.done       = (r_state == S_FIN);
    assign host.busy       = (r_state != S_IDLE);
    assign host.mult_count = r_cnt;
    assign mm.mm_start     = (r_state == S_SQ_ISS) || (r_state == S_MU_ISS) ||
                             (r_state == S_PO_ISS);
    assign mm.mm_a         = r_mm_a;
    assign mm.mm_b         = r_mm_b;
    assign mm.mm_m         = r_mm_m;
endmodule

// File: tb/tb_mont_exp_seq.sv
// Directed-vector bench for mont_exp_seq with a behavioural Montgomery multiplier.
module tb_mont_exp_seq;
    localparam int DW = 512;
    localparam int EW = 512;
    localparam int CW = 11;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic reset;
    logic inj_done;
    always #5 clk = ~clk;

    mont_exp_seq_if #(.DATA_W(DW), .EXP_W(EW), .CNT_W(CW)) host ();
    mont_mm_if #(.DATA_W(DW)) mm ();

    mont_exp_seq #(.DATA_W(DW), .EXP_W(EW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .host  (host),
        .mm    (mm)
    );

    // a*b*2^-DW mod m, bit-serial
    function automatic logic [DW-1:0] montmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] m);
        logic [DW+1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] to_mont(input logic [DW-1:0] x, input logic [DW-1:0] m);
        logic [2*DW-1:0] n, d, q;
        n = {x, {DW{1'b0}}};
        d = {{DW{1'b0}}, m};
        q = n % d;
        return q[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] modexp_ref(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                                 input logic [DW-1:0] m);
        logic [2*DW-1:0] r, xr, d;
        d = {{DW{1'b0}}, m};
        xr = {{DW{1'b0}}, x} % d;
        r = '0;
        r[0] = 1'b1;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % d;
            if (e[i]) r = (r * xr) % d;
        end
        return r[DW-1:0];
    endfunction

    function automatic int exp_count(input logic [EW-1:0] e);
        int pc;
        pc = $countones(e);
`ifdef MONT_EXP_SKIP_LZ_EN
        if (e == '0) return 1;
        for (int i = EW - 1; i >= 0; i--)
            if (e[i]) return i + pc + 1;
        return 1;
`else
        return EW + pc + 1;
`endif
    endfunction

    // behavioural multiplier: 3 cycles after start, checks operand stability meanwhile
    logic          m_busy, m_done_r;
    logic [1:0]    m_cnt;
    logic [DW-1:0] m_a, m_b, m_m, m_res;
    int            stab_err = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done_r <= 1'b0;
            m_cnt    <= '0;
            m_res    <= '0;
            m_a      <= '0;
            m_b      <= '0;
            m_m      <= '0;
        end else begin
            m_done_r <= 1'b0;
            if (!m_busy) begin
                if (mm.mm_start) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 2'd2;
                    m_a    <= mm.mm_a;
                    m_b    <= mm.mm_b;
                    m_m    <= mm.mm_m;
                end
            end else begin
                if (mm.mm_a != m_a || mm.mm_b != m_b || mm.mm_m != m_m)
                    stab_err <= stab_err + 1;
                if (m_cnt == 2'd0) begin
                    m_res    <= montmul(m_a, m_b, m_m);
                    m_done_r <= 1'b1;
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 2'd1;
                end
            end
        end
    end

    assign mm.mm_done   = m_done_r | inj_done;
    assign mm.mm_result = inj_done ? {DW{1'b1}} : m_res;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic run_job(input logic [DW-1:0] x, input logic [DW-1:0] m,
                           input logic [EW-1:0] e, input bit restart, input bit inject,
                           output logic [DW-1:0] res, output logic [DW-1:0] res_hold,
                           output int cnt, output int ndone, output bit tmo,
                           output bit busy1, output bit busy_end, output int stab_d);
        bit injected;
        int stab0;
        stab0 = stab_err;
        injected = 1'b0;
        res = '0;
        cnt = 0;
        @(negedge clk);
        host.x_mont   = to_mont(x, m);
        host.one_mont = to_mont(DW'(1), m);
        host.exp      = e;
        host.mod      = m;
        host.start    = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        busy1 = host.busy;
        ndone = 0;
        tmo   = 1'b1;
        for (int k = 0; k < 20000 && tmo; k++) begin
            if (restart && k == 10) begin
                host.start  = 1'b1;
                host.exp    = ~e;
                host.x_mont = '1;
            end
            if (restart && k == 11) host.start = 1'b0;
            if (inject && !injected && mm.mm_start) begin
                inj_done = 1'b1;
                injected = 1'b1;
            end else begin
                inj_done = 1'b0;
            end
            @(negedge clk);
            if (host.done) begin
                ndone++;
                res = host.result;
                cnt = int'(host.mult_count);
                tmo = 1'b0;
            end
        end
        inj_done = 1'b0;
        @(negedge clk);
        busy_end = host.busy;
        for (int k = 0; k < 4; k++) begin
            if (host.done) ndone++;
            @(negedge clk);
        end
        res_hold = host.result;
        stab_d = stab_err - stab0;
    endtask

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] m;
        logic [EW-1:0] e;
        logic [DW-1:0] exp_res;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        logic [DW-1:0] res, res_hold;
        int cnt, ndone, stab_d;
        bit tmo, busy1, busy_end;
        logic [EW-1:0] e_top;

        reset         = 1'b1;
        inj_done      = 1'b0;
        host.start    = 1'b0;
        host.x_mont   = '0;
        host.one_mont = '0;
        host.exp      = '0;
        host.mod      = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", host.result, '0);
        chk("rst_done", DW'(host.done), '0);
        chk("rst_busy", DW'(host.busy), '0);
        chk("rst_count", DW'(host.mult_count), '0);
        chk("rst_mm_start", DW'(mm.mm_start), '0);
        chk("rst_mm_a", mm.mm_a, '0);
        chk("rst_mm_b", mm.mm_b, '0);
        chk("rst_mm_m", mm.mm_m, '0);
        reset = 1'b0;

        e_top = '0;
        e_top[EW-1] = 1'b1;
        vecs[0] = '{x: DW'(3),  m: DW'(13), e: EW'(5),  exp_res: DW'(9)};
        vecs[1] = '{x: DW'(7),  m: DW'(13), e: EW'(0),  exp_res: DW'(1)};
        vecs[2] = '{x: DW'(20), m: DW'(13), e: EW'(1),  exp_res: DW'(7)};
        vecs[3] = '{x: DW'(2),  m: DW'(11), e: EW'(10), exp_res: DW'(1)};
        vecs[4] = '{x: DW'(5),  m: DW'(7),  e: EW'(3),  exp_res: DW'(6)};
        vecs[5] = '{x: DW'(0),  m: DW'(13), e: EW'(3),  exp_res: DW'(0)};
        vecs[6] = '{x: DW'(3),  m: DW'(13), e: e_top,   exp_res: DW'(9)};
        vecs[7].x = {16{32'h12345678}};
        vecs[7].m = {16{32'hDEADBEEF}};
        vecs[7].e = '1;
        vecs[7].exp_res = modexp_ref(vecs[7].x, vecs[7].e, vecs[7].m);

        for (int i = 0; i < NV; i++) begin
            run_job(vecs[i].x, vecs[i].m, vecs[i].e, 1'b0, 1'b0,
                    res, res_hold, cnt, ndone, tmo, busy1, busy_end, stab_d);
            $display("vec %0d: e_pop=%0d result=%0h count=%0d", i, $countones(vecs[i].e), res, cnt);
            chk($sformatf("v%0d_timeout", i), DW'(tmo), '0);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("v%0d_hold", i), res_hold, vecs[i].exp_res);
            chk($sformatf("v%0d_count", i), DW'(cnt), DW'(exp_count(vecs[i].e)));
            chk($sformatf("v%0d_ndone", i), DW'(ndone), DW'(1));
            chk($sformatf("v%0d_busy", i), DW'(busy1), DW'(1));
            chk($sformatf("v%0d_busy_end", i), DW'(busy_end), '0);
            chk($sformatf("v%0d_stable", i), DW'(stab_d), '0);
        end

        // restart while busy plus a spurious mm_done during the first issue cycle
        run_job(DW'(3), DW'(13), EW'(5), 1'b1, 1'b1,
                res, res_hold, cnt, ndone, tmo, busy1, busy_end, stab_d);
        $display("hazard: result=%0h count=%0d ndone=%0d", res, cnt, ndone);
        chk("hz_timeout", DW'(tmo), '0);
        chk("hz_result", res, DW'(9));
        chk("hz_count", DW'(cnt), DW'(exp_count(EW'(5))));
        chk("hz_ndone", DW'(ndone), DW'(1));
        chk("hz_stable", DW'(stab_d), '0);

        // asynchronous reset in the middle of the first square wait
        @(negedge clk);
        host.x_mont   = to_mont(DW'(3), DW'(13));
        host.one_mont = to_mont(DW'(1), DW'(13));
        host.exp      = EW'(5);
        host.mod      = DW'(13);
        host.start    = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        tmo = 1'b1;
        for (int k = 0; k < 50 && tmo; k++) begin
            if (mm.mm_start) tmo = 1'b0;
            else @(negedge clk);
        end
        chk("ar_reach_iss", DW'(tmo), '0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("async reset: busy=%0b done=%0b mm_start=%0b", host.busy, host.done, mm.mm_start);
        chk("ar_busy", DW'(host.busy), '0);
        chk("ar_done", DW'(host.done), '0);
        chk("ar_mm_start", DW'(mm.mm_start), '0);
        chk("ar_count", DW'(host.mult_count), '0);
        @(negedge clk);
        reset = 1'b0;
        run_job(DW'(3), DW'(13), EW'(5), 1'b0, 1'b0,
                res, res_hold, cnt, ndone, tmo, busy1, busy_end, stab_d);
        $display("after reset: result=%0h count=%0d", res, cnt);
        chk("ar2_timeout", DW'(tmo), '0);
        chk("ar2_result", res, DW'(9));
        chk("ar2_count", DW'(cnt), DW'(exp_count(EW'(5))));
        chk("ar2_ndone", DW'(ndone), DW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
